program_sequencer: RTL and testbench

- Instruction-issue front end for the 16-bit simple processor.
- Holds a small loadable program memory and drives the processor's DIN and run inputs, one instruction at a time.
- Waits for the processor's done before issuing the next word.
- Flags a watchdog error if done never arrives within a bounded number of cycles.

---
 rtl/program_sequencer.sv | 170 +++++++++++++++++
 tb/tb_program_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// Instruction-issue front end: feeds a loaded program word by word to the processor, with a done watchdog.
// Optional single-step mode via PROGRAM_SEQUENCER_SINGLE_STEP_EN (adds step input and PAUSE state).
module program_sequencer #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk_50MHz,
   input  logic              reset_n,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   input  logic              done,
`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic [DATA_W-1:0] DIN,
   output logic              run,
   output logic              busy,
   output logic              finished,
   output logic              timeout_err,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W:0]   instr_count
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned LEN_W  = ADDR_W + 1;
   localparam int unsigned WDOG_W = $clog2(TIMEOUT);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_NEXT   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;
`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
   localparam logic [2:0] S_PAUSE  = 3'd6;
`endif

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [2:0]        state_q, state_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              run_q, busy_q, fin_q, err_q;

   logic [ADDR_W-1:0] pc_inc;
   logic [LEN_W-1:0]  pc_inc_ext;
   logic              wr_ok;

   assign pc_inc     = pc_q + ADDR_W'(1);
   assign pc_inc_ext = {1'b0, pc_q} + LEN_W'(1);
   assign wr_ok      = (state_q == S_IDLE) || (state_q == S_ERROR);

   // Program memory is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk_50MHz) begin
      if (prog_we && wr_ok) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_comb begin
      state_d = state_q;
      din_d   = din_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      wdog_d  = wdog_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d  = '0;
               cnt_d = '0;
               if (prog_len == '0) begin
                  len_d   = '0;
                  state_d = S_FINISH;
               end else begin
                  len_d   = prog_len;
                  din_d   = mem_q[0];
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done wins over an expiring watchdog on the same edge
            if (done) begin
               cnt_d   = cnt_q + LEN_W'(1);
               state_d = S_NEXT;
            end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
               state_d = S_ERROR;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         S_NEXT: begin
            if (pc_inc_ext == len_q) begin
               state_d = S_FINISH;
            end else begin
`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
               state_d = S_PAUSE;
`else
               pc_d    = pc_inc;
               din_d   = mem_q[pc_inc];
               state_d = S_ISSUE;
`endif
            end
         end
`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
         S_PAUSE: begin
            if (step) begin
               pc_d    = pc_inc;
               din_d   = mem_q[pc_inc];
               state_d = S_ISSUE;
            end
         end
`endif
         S_FINISH: state_d = S_IDLE;
         S_ERROR: begin
            if (start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         din_q   <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         wdog_q  <= '0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         din_q   <= din_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         wdog_q  <= wdog_d;
         run_q   <= (state_d == S_ISSUE);
         busy_q  <= (state_d != S_IDLE) && (state_d != S_ERROR);
         fin_q   <= (state_d == S_FINISH);
         err_q   <= (state_d == S_ERROR);
      end
   end

   assign DIN         = din_q;
   assign run         = run_q;
   assign busy        = busy_q;
   assign finished    = fin_q;
   assign timeout_err = err_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: vector table of whole programs plus hand-written corner sequences.
module tb_program_sequencer;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned DEPTH   = 2 ** ADDR_W;
`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
   localparam int unsigned PAUSE_EXTRA = 1;
`else
   localparam int unsigned PAUSE_EXTRA = 0;
`endif

   logic              clk_50MHz = 1'b0;
   logic              reset_n;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic [ADDR_W:0]   prog_len;
   logic              start;
   logic              done;
   logic              step;
   logic [DATA_W-1:0] DIN;
   logic              run, busy, finished, timeout_err;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W:0]   instr_count;

   always #10 clk_50MHz = ~clk_50MHz;

   program_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_50MHz(clk_50MHz), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start), .done(done),
`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
      .step(step),
`endif
      .DIN(DIN), .run(run), .busy(busy), .finished(finished), .timeout_err(timeout_err),
      .pc(pc), .instr_count(instr_count)
   );

   typedef struct {
      int unsigned len;
      int unsigned dly;       // done arrives this many cycles after run; 0 = never
      int unsigned exp_runs;
      int unsigned exp_cnt;
      int unsigned exp_pc;
      bit          exp_err;
   } vec_t;

   vec_t              vecs [7];
   logic [DATA_W-1:0] exp_mem [DEPTH];
   logic [DATA_W-1:0] din_log [64];
   int unsigned       run_cnt = 0;
   int unsigned       fin_cnt = 0;
   int unsigned       done_dly = 3;
   int unsigned       total = 0;
   int unsigned       bad = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Processor model: pulse done a fixed number of cycles after each run.
   initial begin
      done = 1'b0;
      forever begin
         @(negedge clk_50MHz);
         if (run && done_dly != 0) begin
            repeat (done_dly) @(negedge clk_50MHz);
            done = 1'b1;
            @(negedge clk_50MHz);
            done = 1'b0;
         end
      end
   end

   always @(negedge clk_50MHz) begin
      if (run) begin
         if (run_cnt < 64) din_log[run_cnt] = DIN;
         run_cnt = run_cnt + 1;
      end
      if (finished) fin_cnt = fin_cnt + 1;
   end

   task automatic pulse_start(input int unsigned len);
      @(negedge clk_50MHz);
      prog_len = (ADDR_W+1)'(len);
      start = 1'b1;
      @(negedge clk_50MHz);
      start = 1'b0;
   endtask

   task automatic wait_end(output int unsigned cyc);
      cyc = 0;
      while (!finished && !timeout_err && cyc < 4000) begin
         @(negedge clk_50MHz);
         cyc++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int unsigned cyc;
      int unsigned r0;
      done_dly = v.dly;
      run_cnt  = 0;
      fin_cnt  = 0;
      pulse_start(v.len);
      wait_end(cyc);
      chk("end_reached", (cyc < 4000) ? 1 : 0, 1);
      chk("timeout_err", timeout_err, v.exp_err);
      if (v.exp_err) begin
         chk("err_busy", busy, 0);
         r0 = run_cnt;
         pulse_start(0);
         chk("err_clear", timeout_err, 0);
         repeat (5) @(negedge clk_50MHz);
         chk("err_no_run", run_cnt, r0);
         chk("err_idle_busy", busy, 0);
      end else begin
         chk("fin_pulse", finished, 1);
         @(negedge clk_50MHz);
         chk("fin_one_cycle", finished, 0);
         chk("idle_busy", busy, 0);
      end
      chk("fin_count", fin_cnt, v.exp_err ? 0 : 1);
      chk("run_count", run_cnt, v.exp_runs);
      chk("instr_count", instr_count, v.exp_cnt);
      chk("pc", pc, v.exp_pc);
      for (int unsigned i = 0; i < v.exp_runs && i < 64; i++) begin
         chk($sformatf("din[%0d]", i), din_log[i], exp_mem[i]);
      end
   endtask

   initial begin
      int unsigned c;
      reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      prog_len = '0; start = 1'b0; step = 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) exp_mem[i] = 16'h5A00 + 16'(i);
      exp_mem[0] = 16'h1000; exp_mem[1] = 16'h2001; exp_mem[2] = 16'h3002;

      vecs[0] = '{len: 3,  dly: 3,  exp_runs: 3,  exp_cnt: 3,  exp_pc: 2,  exp_err: 0};
      vecs[1] = '{len: 0,  dly: 3,  exp_runs: 0,  exp_cnt: 0,  exp_pc: 0,  exp_err: 0};
      vecs[2] = '{len: 1,  dly: 1,  exp_runs: 1,  exp_cnt: 1,  exp_pc: 0,  exp_err: 0};
      vecs[3] = '{len: 32, dly: 2,  exp_runs: 32, exp_cnt: 32, exp_pc: 31, exp_err: 0};
      vecs[4] = '{len: 2,  dly: 64, exp_runs: 2,  exp_cnt: 2,  exp_pc: 1,  exp_err: 0};
      vecs[5] = '{len: 3,  dly: 65, exp_runs: 1,  exp_cnt: 0,  exp_pc: 0,  exp_err: 1};
      vecs[6] = '{len: 2,  dly: 0,  exp_runs: 1,  exp_cnt: 0,  exp_pc: 0,  exp_err: 1};

      #25;
      chk("rst_run", run, 0);
      chk("rst_din", DIN, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fin", finished, 0);
      chk("rst_err", timeout_err, 0);
      chk("rst_pc", pc, 0);
      chk("rst_cnt", instr_count, 0);
      @(negedge clk_50MHz);
      reset_n = 1'b1;

      for (int unsigned i = 0; i < DEPTH; i++) begin
         @(negedge clk_50MHz);
         prog_we = 1'b1; prog_addr = ADDR_W'(i); prog_data = exp_mem[i];
      end
      @(negedge clk_50MHz);
      prog_we = 1'b0;

      for (int unsigned i = 0; i < 7; i++) run_vec(vecs[i]);

      // Start-to-run latency, write ignored while busy, done-to-run latency
      done_dly = 10; run_cnt = 0;
      pulse_start(3);
      chk("start_to_run", run, 1);
      @(negedge clk_50MHz);
      prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'hBEEF;
      @(negedge clk_50MHz);
      prog_we = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_run", run, 0);
      c = 2;
      while (!run && c < 200) begin
         @(negedge clk_50MHz);
         c++;
      end
      chk("done_to_run_gap", c, 12 + PAUSE_EXTRA);
      chk("we_ignored_din", DIN, 16'h2001);
      wait_end(c);
      chk("we_seq_fin", finished, 1);
      chk("we_seq_runs", run_cnt, 3);
      chk("we_seq_din2", din_log[2], 16'h3002);

      // Watchdog expiry cycle count
      done_dly = 0;
      pulse_start(2);
      c = 0;
      while (!timeout_err && c < 500) begin
         @(negedge clk_50MHz);
         c++;
      end
      chk("wdog_cycles", c, TIMEOUT + 1);
      pulse_start(0);
      chk("wdog_clear", timeout_err, 0);

      // Asynchronous reset mid-WAIT of instruction 2, then replay
      done_dly = 5; run_cnt = 0;
      pulse_start(3);
      c = 0;
      while (run_cnt < 2 && c < 500) begin
         @(negedge clk_50MHz);
         c++;
      end
      repeat (2) @(negedge clk_50MHz);
      chk("pre_rst_pc", pc, 1);
      reset_n = 1'b0;
      #1;
      chk("arst_run", run, 0);
      chk("arst_din", DIN, 0);
      chk("arst_pc", pc, 0);
      chk("arst_cnt", instr_count, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk_50MHz);
      reset_n = 1'b1;
      repeat (10) @(negedge clk_50MHz);
      run_vec(vecs[0]);

`ifdef PROGRAM_SEQUENCER_SINGLE_STEP_EN
      step = 1'b0; done_dly = 3; run_cnt = 0;
      pulse_start(2);
      repeat (15) @(negedge clk_50MHz);
      chk("pause_runs", run_cnt, 1);
      chk("pause_busy", busy, 1);
      chk("pause_cnt", instr_count, 1);
      chk("pause_pc", pc, 0);
      step = 1'b1;
      @(negedge clk_50MHz);
      step = 1'b0;
      chk("step_run", run, 1);
      chk("step_din", DIN, 16'h2001);
      wait_end(c);
      chk("step_fin", finished, 1);
      step = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
